// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS core: multiply/divide opcodes and the HI/LO unit state.
package mips_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_NOP0  = 3'b110,
    OP_NOP1  = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } md_state_e;

endpackage

// File: rtl/sc_md_core.sv
// Iteration datapath for mult/div: magnitude registers, 2*WIDTH accumulator,
// one shift-add / restoring-subtract step per cycle, and the final sign fixup.
module sc_md_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             step,
  input  logic             div_op,
  input  logic             sgn_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   ma, mb;
  logic               is_div, neg_q, neg_r;

  logic               sa, sb;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     upper, msum;
  logic [WIDTH+1:0]   diff;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_n;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    sa    = sgn_op & a[WIDTH-1];
    sb    = sgn_op & b[WIDTH-1];
    abs_a = sa ? -a : a;
    abs_b = sb ? -b : b;
    // Division: next dividend bit shifts into the partial remainder.
    upper = {acc[2*WIDTH-1:WIDTH], ma[WIDTH-1]};
    diff  = {1'b0, upper} - {2'b00, mb};
    q_bit = ~diff[WIDTH+1];
    rem_n = q_bit ? diff[WIDTH-1:0] : upper[WIDTH-1:0];
    msum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mb[0] ? {1'b0, ma} : '0);
    prod  = neg_q ? -acc : acc;
    if (is_div) begin
      res_lo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      res_hi = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end else begin
      res_lo = prod[WIDTH-1:0];
      res_hi = prod[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc    <= '0;
      ma     <= '0;
      mb     <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else if (load) begin
      acc    <= '0;
      ma     <= abs_a;
      mb     <= abs_b;
      is_div <= div_op;
      // Divide-by-zero: quotient stays all ones and the remainder negation
      // restores the original dividend.
      neg_q  <= (sa ^ sb) & ~(div_op && b == '0);
      neg_r  <= sa;
    end else if (step) begin
      if (is_div) begin
        ma  <= ma << 1;
        acc <= {rem_n, acc[WIDTH-2:0], q_bit};
      end else begin
        mb  <= mb >> 1;
        acc <= {msum, acc[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/sc_mul_div_unit.sv
// HI/LO multiply/divide unit: IDLE/RUN/FIN control, iteration counter and the
// architectural HI/LO registers around the sc_md_core datapath.
module sc_mul_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  md_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic             accept, md_go, step;
  logic [WIDTH-1:0] res_hi, res_lo;

  always_comb begin
    accept = enable & start & (state == ST_IDLE);
    md_go  = accept & ~op[2];
    step   = enable & (state == ST_RUN);
  end

  sc_md_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (md_go),
    .step   (step),
    .div_op (op[1]),
    .sgn_op (~op[0]),
    .a      (operand_a),
    .b      (operand_b),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (enable) begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          case (md_op_e'(op))
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              state <= ST_RUN;
              cnt   <= '0;
              busy  <= 1'b1;
            end
            OP_MTHI: hi <= operand_a;
            OP_MTLO: lo <= operand_a;
            default: ;
          endcase
        end
        ST_RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= ST_FIN;
        end
        ST_FIN: begin
          hi    <= res_hi;
          lo    <= res_lo;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_mul_div_unit.sv
// Directed + random checks of sc_mul_div_unit against a plain-arithmetic HI/LO model.
module tb_sc_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b110;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic [31:0] hi, lo;
  logic        busy, done;

  int checks = 0;
  int fails  = 0;

  sc_mul_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: MIPS HI/LO semantics computed directly with integer arithmetic.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el);
    longint sp;
    logic [63:0] up;
    case (o)
      3'b000: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        {eh, el} = sp;
      end
      3'b001: begin
        up = {32'd0, a} * {32'd0, b};
        {eh, el} = up;
      end
      3'b010: begin
        if (b == 0) begin el = 32'hFFFF_FFFF; eh = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin el = 32'h8000_0000; eh = 0; end
        else begin el = $signed(a) / $signed(b); eh = $signed(a) % $signed(b); end
      end
      default: begin
        if (b == 0) begin el = 32'hFFFF_FFFF; eh = a; end
        else begin el = a / b; eh = a % b; end
      end
    endcase
  endtask

  // Issues one mult/div with enable held high; caller is #1 after a rising edge.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [31:0] eh, el, oh, ol;
    int cyc;
    bit hold_ok;
    model(o, a, b, eh, el);
    oh = hi; ol = lo;
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; hold_ok = 1'b1;
    while (!done && cyc < 100) begin
      if (busy !== 1'b1 || hi !== oh || lo !== ol) hold_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'd33);
    chk({tag, "_hold"}, 64'(hold_ok), 64'd1);
    chk({tag, "_hi"}, 64'(hi), 64'(eh));
    chk({tag, "_lo"}, 64'(lo), 64'(el));
    chk({tag, "_busy0"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb, old_hi;
    logic [2:0]  ro;
    int cyc;

    #12;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    run_op(3'b000, 32'hFFFF_FFFD, 32'd7, "mult_neg");
    run_op(3'b000, 32'h8000_0000, 32'h8000_0000, "mult_min");
    run_op(3'b010, 32'hFFFF_FFF9, 32'd2, "div_neg");
    run_op(3'b011, 32'd100, 32'd7, "divu");
    run_op(3'b010, 32'd5, 32'd0, "div_zero");
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(3'b010, 32'hFFFF_FFF9, 32'd0, "div_zero_neg");
    run_op(3'b011, 32'h8000_0001, 32'd0, "divu_zero");

    for (int i = 0; i < 16; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1, 2:    rb = 32'($urandom_range(1, 20));
        3:       rb = -32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, $sformatf("rnd%0d", i));
    end

    // Op 110 is a no-op: no state change.
    old_hi = hi;
    start = 1'b1; op = 3'b110; operand_a = 32'hDEAD_BEEF;
    @(posedge clk); #1; start = 1'b0;
    chk("nop_hi", 64'(hi), 64'(old_hi));
    chk("nop_busy", 64'(busy), 64'd0);

    // MULTU 3*4 with a 10-cycle stall and an ignored MTHI while busy.
    old_hi = hi;
    start = 1'b1; op = 3'b001; operand_a = 32'd3; operand_b = 32'd4;
    @(posedge clk); #1; start = 1'b0;
    cyc = 0;
    while (!done && cyc < 100) begin
      start = (cyc == 2); op = 3'b100; operand_a = 32'hCAFE_F00D;
      enable = !(cyc >= 5 && cyc < 15);
      @(posedge clk); #1;
      cyc++;
      if (cyc == 3) chk("mthi_busy_hi", 64'(hi), 64'(old_hi));
    end
    start = 1'b0; enable = 1'b1;
    chk("stall_lat", 64'(cyc), 64'd43);
    chk("stall_hi", 64'(hi), 64'd0);
    chk("stall_lo", 64'(lo), 64'd12);
    enable = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("done_hold", 64'(done), 64'd1);
    enable = 1'b1;
    @(posedge clk); #1;
    chk("done_clear", 64'(done), 64'd0);

    // Asynchronous reset mid-DIVU.
    chk("pre_rst_lo", 64'(lo), 64'd12);
    start = 1'b1; op = 3'b011; operand_a = 32'd1000; operand_b = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    repeat (15) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; op = 3'b101; operand_a = 32'h1234;
    @(posedge clk); #1; start = 1'b0;
    chk("mtlo_lo", 64'(lo), 64'h1234);
    chk("mtlo_busy", 64'(busy), 64'd0);
    chk("mtlo_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    chk("mtlo_busy2", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/sc_mul_div_unit.md
# sc_mul_div_unit

Iterative multiply/divide unit for the single-cycle MIPS core, with the architectural HI/LO register pair. Sits directly downstream of the register file: consumes its two read-data outputs as operands for MULT/MULTU/DIV/DIVU/MTHI/MTLO. Holds the result in HI/LO for later MFHI/MFLO. Reports `busy` so the core can stall while an operation is in flight.

## Interface
Parameters:
- `WIDTH`, 32: operand width and HI/LO width.
- `CNT_W`, 5: iteration counter width, equal to log2(WIDTH).

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset_n`  in  1: reset, asynchronous and active-low.
- `enable`  in  1: global stall enable; when 0, all state is frozen.
- `start`  in  1: request to issue the operation in `op`.
- `op`  in  3: operation. 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op.
- `operand_a`  in  WIDTH: rs value (multiplicand/dividend/MTxx source).
- `operand_b`  in  WIDTH: rt value (multiplier/divisor).
- `hi`  out  WIDTH: HI register.
- `lo`  out  WIDTH: LO register.
- `busy`  out  1: operation in flight.
- `done`  out  1: one-cycle pulse when HI/LO have just been written by mult/div.

## Operation
- A request is accepted on a rising edge where `enable`=1, `start`=1, and the state is IDLE.
  - `start` while busy is ignored.
  - `start` with `enable`=0 is ignored.
- MTHI/MTLO:
  - `hi`/`lo` take `operand_a` at the accepting edge.
  - The unit never leaves IDLE, and `done` is not pulsed.
- Op codes 110/111: no effect.
- Mult/div at the accepting edge:
  - Latch the operand magnitudes. For signed ops, take the two's-complement absolute value; for unsigned ops, use the value as-is.
  - Latch the result sign flags: quotient/product sign = sign_a XOR sign_b; remainder sign = sign_a. Flags are 0 for unsigned ops.
  - Clear the 64-bit accumulator and the counter, then go to RUN.
- RUN, one iteration per enabled edge, 32 iterations total, with the counter going 0..31:
  - Multiply: unsigned shift-add. If the multiplier LSB is set, add the multiplicand into the upper accumulator half; then shift right 1.
  - Divide: restoring division on the {remainder, quotient} pair. Shift left 1; subtract the divisor from the upper half; if the result is non-negative, keep it and set quotient bit 0.
  - When the counter reaches 31, go to FIN.
- FIN, one enabled edge:
  - Apply the sign fixups (negate product, quotient, remainder per the flags).
  - Mult: `hi` = product[63:32], `lo` = product[31:0].
  - Div: `lo` = quotient, `hi` = remainder.
  - Go to IDLE.
- Divide special cases, decided:
  - Divisor 0: `lo`=0xFFFFFFFF, `hi`=dividend (operand_a unmodified). Applies to DIV and DIVU.
  - DIV 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
  - Both special cases still take the full 33-cycle latency.
- States: IDLE → RUN (on accepted mult/div) → FIN (after iteration 31) → IDLE.

## Timing
- Reset (`reset_n`=0, asynchronous, any time including mid-operation):
  - State IDLE, counter 0, accumulator 0.
  - `hi`=0, `lo`=0, `busy`=0, `done`=0.
  - Any in-flight result is discarded.
- `busy` is registered: 1 from the accepting edge E0 until edge E33, i.e. 1 in RUN and FIN.
- With `enable` held at 1:
  - Edges E1..E32 are the iterations; E33 is the FIN write.
  - `hi`/`lo` hold the new values after E33.
  - `done`=1 for exactly the cycle after E33, and `busy`=0 in that same cycle.
- Latency is 33 enabled cycles.
  - Each `enable`=0 cycle adds one cycle.
  - While `enable`=0, `done` holds its value.
- `hi`/`lo` keep their old values throughout RUN. They change only at FIN, at an MTxx edge, or at reset.
- A new request may be accepted on the edge where `done` is 1, since the state is IDLE then.

## Structure
- Shared package `mips_pkg` holds:
  - `md_op_e` enum (the 3-bit encodings above).
  - `md_state_e` enum (IDLE, RUN, FIN).
- One sub-module, `sc_md_core`, holds the iteration datapath: accumulator, magnitude registers, one-step add/subtract, and sign fixup.
- The top level `sc_mul_div_unit` holds the FSM, the counter, and the HI/LO registers.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `busy` 1 for 33 cycles, `done` pulse, `hi`=0xFFFFFFFE, `lo`=0x00000001.
- MULT 0xFFFFFFFD (−3) × 7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB; MULT 0x80000000 × 0x80000000 → `hi`=0x40000000, `lo`=0.
- DIV 0xFFFFFFF9 (−7) / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF; DIVU 100 / 7 → `lo`=14, `hi`=2.
- DIV 5 / 0 → `lo`=0xFFFFFFFF, `hi`=5; DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0; both still 33 cycles.
- MULTU 3 × 4, then hold `enable`=0 for 10 cycles mid-RUN → `done` arrives at cycle 43, `hi`=0, `lo`=12; `start` with MTHI during `busy` → `hi` unchanged.
- Drop `reset_n` at cycle 15 of a DIVU → `busy`=0, `hi`=`lo`=0 immediately; after release, MTLO 0x1234 → `lo`=0x1234 after the next edge, `busy` stays 0.
